// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, captures inst_mem output into IF/ID,
// and handles stall, branch redirect and a sticky halt on a misaligned redirect.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 32,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc_out,
  input  logic [31:0] inst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        if_id_valid,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic [31:0] fetch_count,
  output logic        misalign_err
);

  // Keeps only the log2(IMEM_BYTES) low address bits so every PC wraps.
  localparam logic [31:0] ADDR_MASK = IMEM_BYTES - 1;

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t      state_reg;
  logic        redirect;
  logic        target_aligned;
  logic [31:0] pc_seq;
  logic [31:0] pc_target;

  // A redirect only means something when IF/ID holds a real instruction.
  assign redirect       = branch_taken & if_id_valid;
  assign target_aligned = (branch_target[1:0] == 2'b00);
  assign pc_seq         = (pc_out + 32'd4) & ADDR_MASK;
  assign pc_target      = branch_target & ADDR_MASK;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= BOOT;
      pc_out         <= RESET_PC & ADDR_MASK;
      if_id_valid    <= 1'b0;
      if_id_inst     <= NOP_INST;
      if_id_pc       <= 32'd0;
      if_id_pc_plus4 <= 32'd4;
      fetch_count    <= 32'd0;
      misalign_err   <= 1'b0;
    end else begin
      case (state_reg)
        BOOT: state_reg <= RUN;
        RUN: begin
          if (redirect) begin
            if_id_valid <= 1'b0;
            if_id_inst  <= NOP_INST;
            if (!target_aligned) begin
              state_reg    <= HALT;
              misalign_err <= 1'b1;
            end else begin
              pc_out <= pc_target;
            end
          end else if (!stall) begin
            if_id_inst     <= inst;
            if_id_pc       <= pc_out;
            if_id_pc_plus4 <= pc_seq;
            if_id_valid    <= 1'b1;
            pc_out         <= pc_seq;
            fetch_count    <= fetch_count + 32'd1;
          end
        end
        HALT: state_reg <= HALT;
        default: state_reg <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// stall/redirect traffic against a behavioural model of the fetch rules.
module tb_fetch_stage;
  localparam int unsigned IMEM = 32;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_out, inst, branch_target;
  logic [31:0] if_id_inst, if_id_pc, if_id_pc_plus4, fetch_count;
  logic        stall, branch_taken, if_id_valid, misalign_err;

  logic [31:0] mem [8];
  int n_cmp = 0;
  int n_fail = 0;

  // behavioural model state
  int          m_phase;  // 0 boot, 1 run, 2 halt
  logic [31:0] m_pc, m_inst, m_ipc, m_p4, m_cnt;
  logic        m_valid, m_err;

  always #5 clk = ~clk;

  assign inst = mem[pc_out[4:2]];

  fetch_stage #(.RESET_PC(32'h0), .IMEM_BYTES(IMEM), .NOP_INST(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .pc_out(pc_out), .inst(inst), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .if_id_valid(if_id_valid), .if_id_inst(if_id_inst), .if_id_pc(if_id_pc),
    .if_id_pc_plus4(if_id_pc_plus4), .fetch_count(fetch_count),
    .misalign_err(misalign_err)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0; m_pc <= 0; m_valid <= 0; m_inst <= NOP;
      m_ipc <= 0; m_p4 <= 4; m_cnt <= 0; m_err <= 0;
    end else if (m_phase == 0) begin
      m_phase <= 1;
    end else if (m_phase == 1) begin
      if (branch_taken && m_valid) begin
        m_valid <= 0;
        m_inst  <= NOP;
        if (branch_target % 4 != 0) begin
          m_phase <= 2;
          m_err   <= 1;
        end else begin
          m_pc <= branch_target % IMEM;
        end
      end else if (!stall) begin
        m_inst  <= mem[(m_pc % IMEM) / 4];
        m_ipc   <= m_pc;
        m_p4    <= (m_pc + 4) % IMEM;
        m_valid <= 1;
        m_pc    <= (m_pc + 4) % IMEM;
        m_cnt   <= m_cnt + 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({pc_out, if_id_valid, if_id_inst, if_id_pc, if_id_pc_plus4, fetch_count, misalign_err}
        !== {32'h0, 1'b0, NOP, 32'h0, 32'h4, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: got pc=%h v=%b inst=%h ipc=%h p4=%h cnt=%0d err=%b",
               pc_out, if_id_valid, if_id_inst, if_id_pc, if_id_pc_plus4, fetch_count, misalign_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_cmp++;
    if ({if_id_valid, pc_out, fetch_count} !== {1'b0, 32'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL boot_edge: got v=%b pc=%h cnt=%0d want v=0 pc=0 cnt=0", if_id_valid, pc_out, fetch_count);
    end
    step();
    n_cmp++;
    if ({if_id_valid, if_id_inst, if_id_pc, pc_out, fetch_count} !== {1'b1, 32'h0000_2083, 32'h0, 32'h4, 32'h1}) begin
      n_fail++;
      $display("FAIL first_fetch: got v=%b inst=%h ipc=%h pc=%h cnt=%0d want 1/00002083/0/4/1",
               if_id_valid, if_id_inst, if_id_pc, pc_out, fetch_count);
    end
    $display("reset/boot: inst=%h pc=%h cnt=%0d", if_id_inst, pc_out, fetch_count);
  endtask

  task automatic test_seq_wrap();
    for (int i = 1; i <= 8; i++) begin
      logic [31:0] exp_pc;
      exp_pc = (4 * i) % IMEM;
      step();
      n_cmp++;
      if ({if_id_valid, if_id_pc, if_id_inst} !== {1'b1, exp_pc, mem[exp_pc / 4]}) begin
        n_fail++;
        $display("FAIL seq_pc[%0d]: got v=%b ipc=%h inst=%h want ipc=%h inst=%h",
                 i, if_id_valid, if_id_pc, if_id_inst, exp_pc, mem[exp_pc / 4]);
      end
      $display("seq: ipc=%h inst=%h", if_id_pc, if_id_inst);
    end
    n_cmp++;
    if ({if_id_pc_plus4, fetch_count, pc_out} !== {32'h4, 32'd9, 32'h4}) begin
      n_fail++;
      $display("FAIL wrap: got p4=%h cnt=%0d pc=%h want 4/9/4", if_id_pc_plus4, fetch_count, pc_out);
    end
  endtask

  task automatic test_stall();
    step();
    step();
    n_cmp++;
    if (if_id_pc !== 32'h8) begin
      n_fail++;
      $display("FAIL stall_setup: got ipc=%h want 8", if_id_pc);
    end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if ({pc_out, if_id_inst, if_id_pc, fetch_count, if_id_valid} !== {32'hC, 32'h0020_E233, 32'h8, 32'd11, 1'b1}) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got pc=%h inst=%h ipc=%h cnt=%0d want c/0020e233/8/11",
                 i, pc_out, if_id_inst, if_id_pc, fetch_count);
      end
      $display("stall: pc=%h inst=%h", pc_out, if_id_inst);
    end
    stall = 1'b0;
    step();
    n_cmp++;
    if ({if_id_pc, if_id_inst, fetch_count} !== {32'hC, 32'h0020_81B3, 32'd12}) begin
      n_fail++;
      $display("FAIL stall_release: got ipc=%h inst=%h cnt=%0d want c/002081b3/12", if_id_pc, if_id_inst, fetch_count);
    end
  endtask

  task automatic test_branch();
    repeat (4) step();
    n_cmp++;
    if ({if_id_pc, if_id_inst} !== {32'd28, 32'hFE42_00E3}) begin
      n_fail++;
      $display("FAIL branch_setup: got ipc=%h inst=%h want 1c/fe4200e3", if_id_pc, if_id_inst);
    end
    branch_taken = 1'b1; branch_target = 32'h0; stall = 1'b1;
    step();
    branch_taken = 1'b0; stall = 1'b0;
    n_cmp++;
    if ({if_id_valid, if_id_inst, pc_out, fetch_count} !== {1'b0, NOP, 32'h0, 32'd16}) begin
      n_fail++;
      $display("FAIL branch_flush: got v=%b inst=%h pc=%h cnt=%0d want 0/nop/0/16", if_id_valid, if_id_inst, pc_out, fetch_count);
    end
    step();
    n_cmp++;
    if ({if_id_valid, if_id_pc, if_id_inst, fetch_count} !== {1'b1, 32'h0, 32'h0000_2083, 32'd17}) begin
      n_fail++;
      $display("FAIL branch_target_fetch: got v=%b ipc=%h inst=%h cnt=%0d want 1/0/00002083/17",
               if_id_valid, if_id_pc, if_id_inst, fetch_count);
    end
    $display("branch: ipc=%h inst=%h", if_id_pc, if_id_inst);
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      stall         = ($urandom_range(0, 3) == 0);
      branch_taken  = ($urandom_range(0, 4) == 0);
      branch_target = $urandom & 32'hFFFF_FFFC;
      step();
      n_cmp++;
      if ({pc_out, if_id_valid, if_id_inst, if_id_pc, if_id_pc_plus4, fetch_count, misalign_err}
          !== {m_pc, m_valid, m_inst, m_ipc, m_p4, m_cnt, m_err}) begin
        n_fail++;
        $display("FAIL random[%0d]: got pc=%h v=%b inst=%h ipc=%h p4=%h cnt=%0d want pc=%h v=%b inst=%h ipc=%h p4=%h cnt=%0d",
                 i, pc_out, if_id_valid, if_id_inst, if_id_pc, if_id_pc_plus4, fetch_count,
                 m_pc, m_valid, m_inst, m_ipc, m_p4, m_cnt);
      end
      $display("rand: st=%b br=%b tgt=%h pc=%h v=%b ipc=%h", stall, branch_taken, branch_target, pc_out, if_id_valid, if_id_pc);
    end
    stall = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic test_misalign();
    step();
    branch_taken = 1'b1; branch_target = 32'h0000_0006;
    step();
    n_cmp++;
    if ({misalign_err, if_id_valid, if_id_inst} !== {1'b1, 1'b0, NOP}) begin
      n_fail++;
      $display("FAIL misalign: got err=%b v=%b inst=%h want 1/0/nop", misalign_err, if_id_valid, if_id_inst);
    end
    for (int i = 0; i < 10; i++) begin
      stall         = $urandom_range(0, 1) == 1;
      branch_taken  = 1'b1;
      branch_target = $urandom;
      step();
      n_cmp++;
      if ({pc_out, if_id_valid, if_id_inst, if_id_pc, if_id_pc_plus4, fetch_count, misalign_err}
          !== {m_pc, 1'b0, NOP, m_ipc, m_p4, m_cnt, 1'b1}) begin
        n_fail++;
        $display("FAIL halt_frozen[%0d]: got pc=%h v=%b ipc=%h cnt=%0d err=%b want pc=%h ipc=%h cnt=%0d",
                 i, pc_out, if_id_valid, if_id_pc, fetch_count, misalign_err, m_pc, m_ipc, m_cnt);
      end
      $display("halt: pc=%h err=%b", pc_out, misalign_err);
    end
    stall = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) step();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({pc_out, if_id_valid, if_id_inst, if_id_pc, if_id_pc_plus4, fetch_count, misalign_err}
        !== {32'h0, 1'b0, NOP, 32'h0, 32'h4, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: got pc=%h v=%b inst=%h ipc=%h p4=%h cnt=%0d err=%b",
               pc_out, if_id_valid, if_id_inst, if_id_pc, if_id_pc_plus4, fetch_count, misalign_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_cmp++;
    if ({if_id_valid, pc_out} !== {1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL reboot_edge: got v=%b pc=%h want 0/0", if_id_valid, pc_out);
    end
    step();
    n_cmp++;
    if ({if_id_valid, if_id_inst, if_id_pc, pc_out, fetch_count} !== {1'b1, 32'h0000_2083, 32'h0, 32'h4, 32'h1}) begin
      n_fail++;
      $display("FAIL reboot_fetch: got v=%b inst=%h ipc=%h pc=%h cnt=%0d want 1/00002083/0/4/1",
               if_id_valid, if_id_inst, if_id_pc, pc_out, fetch_count);
    end
    $display("async reset: reboot inst=%h cnt=%0d", if_id_inst, fetch_count);
  endtask

  initial begin
    mem[0] = 32'h0000_2083; mem[1] = 32'h0040_2103;
    mem[2] = 32'h0020_E233; mem[3] = 32'h0020_81B3;
    mem[4] = 32'h0030_A023; mem[5] = 32'h0041_0113;
    mem[6] = 32'h0012_8293; mem[7] = 32'hFE42_00E3;
    stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_seq_wrap();
    test_stall();
    test_branch();
    test_random();
    test_misalign();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
